// File: rtl/wb_burst_master.sv
// wb_burst_master
//   Turns one burst request (read or write, 1..MAX_BURST beats, incrementing
//   or fixed address) into a pipelined Wishbone cycle. It also collects the
//   read beats and reports completion or abort.
//
//   Ports
//     clk, rst             clock, synchronous active-high reset
//     req_*                request channel (valid/ready handshake)
//     wr_data / wr_pop     first-word-fall-through write data source
//     rd_data / rd_valid   read beats, one-cycle pulse per beat
//     done / err           end-of-burst pulse, err marks an abort
//     cyc_o .. dat_o       Wishbone pipelined master outputs
//     dat_i, ack_i,
//     stall_i, err_i       Wishbone slave responses
//
//   Sequencing: IDLE accepts a request. ISSUE strobes beats until all are
//   accepted. DRAIN waits for the remaining acks. Acks received during ISSUE
//   are counted as they arrive.
module wb_burst_master #(
  parameter  int AW        = 8,
  parameter  int DW        = 8,
  parameter  int MAX_BURST = 16,
  parameter  int TIMEOUT   = 255,
  localparam int LW        = $clog2(MAX_BURST) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [LW-1:0] req_len,
  input  logic          req_incr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_pop,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          done,
  output logic          err,
  output logic          cyc_o,
  output logic          stb_o,
  output logic          we_o,
  output logic [AW-1:0] adr_o,
  output logic [DW-1:0] dat_o,
  input  logic [DW-1:0] dat_i,
  input  logic          ack_i,
  input  logic          stall_i,
  input  logic          err_i
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0] MAX_LEN  = LW'(MAX_BURST);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] issued_q, issued_d;
  logic [LW-1:0] acked_q, acked_d;
  logic [LW-1:0] outst_q, outst_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          incr_q, incr_d;

  logic          req_ready_d, cyc_d, stb_d, we_d;
  logic          rd_valid_d, done_d, err_d;
  logic [AW-1:0] adr_d;
  logic [DW-1:0] rd_data_d;

  logic          accept, ack_ok, abort;

  // A beat is taken when the registered strobe meets a low stall_i, and that
  // is only known within the cycle itself. The FWFT head must be consumed in
  // exactly that cycle, so the write data path is gated directly from
  // registered strobe/we and the live stall. While stalled, nothing pops, so
  // wr_data and dat_o hold on their own.
  assign accept = stb_o && !stall_i;
  // Acks are counted only while a beat is outstanding. This also ignores
  // stray acks after an abort or a reset.
  assign ack_ok = cyc_o && ack_i && (outst_q != '0);
  assign wr_pop = accept && we_o;
  assign dat_o  = (stb_o && we_o) ? wr_data : '0;

  always_comb begin
    // NOTE: every signal gets its hold/idle value first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    len_d       = len_q;
    issued_d    = issued_q;
    acked_d     = acked_q;
    outst_d     = outst_q;
    tmo_d       = tmo_q;
    incr_d      = incr_q;
    req_ready_d = req_ready;
    cyc_d       = cyc_o;
    stb_d       = stb_o;
    we_d        = we_o;
    adr_d       = adr_o;
    rd_data_d   = rd_data;
    rd_valid_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    abort       = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready) begin
          state_d     = ISSUE;
          req_ready_d = 1'b0;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          we_d        = req_we;
          adr_d       = req_addr;
          incr_d      = req_incr;
          issued_d    = '0;
          acked_d     = '0;
          outst_d     = '0;
          tmo_d       = '0;
          if (req_len == '0)          len_d = LW'(1);
          else if (req_len > MAX_LEN) len_d = MAX_LEN;
          else                        len_d = req_len;
        end
      end

      ISSUE, DRAIN: begin
        if (accept) begin
          issued_d = issued_q + 1'b1;
          if (incr_q) adr_d = adr_o + 1'b1;  // wraps modulo 2^AW
          if (issued_q + 1'b1 == len_q) begin
            stb_d   = 1'b0;
            state_d = DRAIN;
          end
        end

        if (accept && !ack_ok)      outst_d = outst_q + 1'b1;
        else if (!accept && ack_ok) outst_d = outst_q - 1'b1;

        if (ack_ok) acked_d = acked_q + 1'b1;

        // An ack that coincides with err_i is part of the abort and carries
        // no data.
        if (ack_ok && !we_o && !err_i) begin
          rd_valid_d = 1'b1;
          rd_data_d  = dat_i;
        end

        tmo_d = (accept || ack_ok) ? '0 : tmo_q + 1'b1;
        abort = err_i || (!accept && !ack_ok && tmo_q == TMO_LAST);

        if (abort || (ack_ok && acked_q + 1'b1 == len_q)) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          done_d      = 1'b1;
          err_d       = abort;
          issued_d    = '0;
          acked_d     = '0;
          outst_d     = '0;
          tmo_d       = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments, so every flop
    // samples the values that came out of the previous cycle.
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      issued_q  <= '0;
      acked_q   <= '0;
      outst_q   <= '0;
      tmo_q     <= '0;
      incr_q    <= 1'b0;
      req_ready <= 1'b0;
      cyc_o     <= 1'b0;
      stb_o     <= 1'b0;
      we_o      <= 1'b0;
      adr_o     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      acked_q   <= acked_d;
      outst_q   <= outst_d;
      tmo_q     <= tmo_d;
      incr_q    <= incr_d;
      req_ready <= req_ready_d;
      cyc_o     <= cyc_d;
      stb_o     <= stb_d;
      we_o      <= we_d;
      adr_o     <= adr_d;
      rd_data   <= rd_data_d;
      rd_valid  <= rd_valid_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Self-checking bench for wb_burst_master.
// A negedge process plays the Wishbone slave (it acks one cycle after each
// accept) and the FWFT write source. The same process checks the DUT outputs
// against scoreboard queues that the scenario tasks fill.
module tb_wb_burst_master;

  localparam int AW        = 8;
  localparam int DW        = 8;
  localparam int MAX_BURST = 16;
  localparam int TIMEOUT   = 255;
  localparam int LW        = $clog2(MAX_BURST) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic          req_incr = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_pop;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          done;
  logic          err;
  logic          cyc_o, stb_o, we_o;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic [DW-1:0] dat_i = '0;
  logic          ack_i = 1'b0;
  logic          stall_i = 1'b0;
  logic          err_i = 1'b0;

  wb_burst_master #(
    .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_incr(req_incr),
    .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .err(err),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i), .stall_i(stall_i), .err_i(err_i)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Scoreboard and slave data
  logic [AW-1:0] exp_adr[$];
  logic [DW-1:0] exp_wdat[$];
  logic [DW-1:0] exp_rd[$];
  logic [DW-1:0] rd_src[$];
  logic [DW-1:0] wr_fifo[$];

  // Slave controls (written by tasks at posedge+1, read at negedge)
  logic stall_hold = 1'b0;
  int   err_at_ack = 0;

  // Monitor statistics (written only by the negedge process)
  int   cyc_n = 0, done_cnt = 0, pop_cnt = 0, rdv_cnt = 0;
  int   stb_cnt = 0, stall_stb_cnt = 0, ack_num = 0;
  int   last_ack_cyc = 0, done_cyc = 0;
  logic done_err = 1'b0, done_cyc_o = 1'b0, done_rdy = 1'b0;
  logic ack_pend = 1'b0;

  always @(negedge clk) begin
    logic [DW-1:0] tmp;
    cyc_n++;
    // Drive slave responses and FWFT head for this cycle.
    ack_i = ack_pend;
    err_i = 1'b0;
    if (ack_pend) begin
      ack_num++;
      if (ack_num == err_at_ack) err_i = 1'b1;
      if (rd_src.size() > 0) dat_i = rd_src.pop_front();
      else                   dat_i = '0;
    end
    stall_i = stall_hold;
    wr_data = (wr_fifo.size() > 0) ? wr_fifo[0] : '0;
    #1;
    if (cyc_o === 1'b1 && ack_i) last_ack_cyc = cyc_n;
    if (stb_o === 1'b1) begin
      stb_cnt++;
      if (stall_i) stall_stb_cnt++;
      total_cnt++;
      if (exp_adr.size() == 0)
        $display("FAIL adr_unexpected: strobe with adr_o=%h, no beat expected", adr_o);
      else if (adr_o !== exp_adr[0])
        $display("FAIL adr: got %h want %h", adr_o, exp_adr[0]);
      else pass_cnt++;
      if (!stall_i) begin
        if (exp_adr.size() > 0) tmp = exp_adr.pop_front();
        if (we_o === 1'b1) begin
          total_cnt++;
          if (exp_wdat.size() == 0)
            $display("FAIL wdat_unexpected: dat_o=%h", dat_o);
          else if (dat_o !== exp_wdat[0] || wr_pop !== 1'b1)
            $display("FAIL wdat: got dat_o=%h wr_pop=%b want %h/1", dat_o, wr_pop, exp_wdat[0]);
          else pass_cnt++;
          if (exp_wdat.size() > 0) tmp = exp_wdat.pop_front();
        end
      end
    end
    if (wr_pop === 1'b1) begin
      pop_cnt++;
      if (wr_fifo.size() > 0) tmp = wr_fifo.pop_front();
    end
    if (rd_valid === 1'b1) begin
      rdv_cnt++;
      total_cnt++;
      if (exp_rd.size() == 0)
        $display("FAIL rd_unexpected: rd_valid with rd_data=%h", rd_data);
      else if (rd_data !== exp_rd[0])
        $display("FAIL rd_data: got %h want %h", rd_data, exp_rd[0]);
      else pass_cnt++;
      if (exp_rd.size() > 0) tmp = exp_rd.pop_front();
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc   = cyc_n;
      done_err   = err;
      done_cyc_o = cyc_o;
      done_rdy   = req_ready;
    end
    if (err === 1'b1 && done !== 1'b1) begin
      total_cnt++;
      $display("FAIL err_without_done: err=1 done=%b want done=1", done);
    end
    ack_pend = (cyc_o === 1'b1) && (stb_o === 1'b1) && !stall_i;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    exp_adr.delete();
    exp_wdat.delete();
    exp_rd.delete();
    rd_src.delete();
    wr_fifo.delete();
  endtask

  task automatic issue_req(input logic we, input logic [AW-1:0] addr,
                           input logic [LW-1:0] len, input logic incr);
    int n = 0;
    req_we = we; req_addr = addr; req_len = len; req_incr = incr;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 50) begin tick(); n++; end
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL req_ready_wait: got %b want 1 within 50 cycles", req_ready);
    else pass_cnt++;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int start, input int budget);
    int n = 0;
    while (done_cnt == start && n < budget) begin tick(); n++; end
    total_cnt++;
    if (done_cnt != start + 1)
      $display("FAIL done_wait: got %0d done pulses want 1 within %0d cycles", done_cnt - start, budget);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total_cnt++;
    if ({req_ready, cyc_o, stb_o, we_o, done, err, rd_valid, wr_pop} !== 8'b0)
      $display("FAIL reset_ctrl: got %b want 00000000",
               {req_ready, cyc_o, stb_o, we_o, done, err, rd_valid, wr_pop});
    else pass_cnt++;
    total_cnt++;
    if ({adr_o, dat_o, rd_data} !== 24'h0)
      $display("FAIL reset_data: got adr=%h dat=%h rd=%h want 0", adr_o, dat_o, rd_data);
    else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++;
    if (req_ready !== 1'b1 || cyc_o !== 1'b0)
      $display("FAIL reset_release: got ready=%b cyc=%b want 1/0", req_ready, cyc_o);
    else pass_cnt++;
  endtask

  task automatic test_write_incr();
    int d0 = done_cnt, p0 = pop_cnt;
    for (int i = 0; i < 4; i++) begin
      wr_fifo.push_back(DW'(8'hA0 + i));
      exp_wdat.push_back(DW'(8'hA0 + i));
      exp_adr.push_back(AW'(8'h80 + i));
    end
    issue_req(1'b1, 8'h80, 5'd4, 1'b1);
    wait_done(d0, 100);
    total_cnt++;
    if (done_err !== 1'b0 || done_cyc_o !== 1'b0 || done_rdy !== 1'b1)
      $display("FAIL wr_done: got err=%b cyc=%b ready=%b want 0/0/1", done_err, done_cyc_o, done_rdy);
    else pass_cnt++;
    total_cnt++;
    if (done_cyc != last_ack_cyc + 1)
      $display("FAIL wr_done_latency: got %0d want 1", done_cyc - last_ack_cyc);
    else pass_cnt++;
    total_cnt++;
    if (pop_cnt - p0 != 4 || exp_adr.size() != 0 || exp_wdat.size() != 0)
      $display("FAIL wr_beats: got pops=%0d adr_left=%0d wdat_left=%0d want 4/0/0",
               pop_cnt - p0, exp_adr.size(), exp_wdat.size());
    else pass_cnt++;
    flush();
  endtask

  task automatic test_read_stall();
    int d0 = done_cnt, r0 = rdv_cnt, s0 = stall_stb_cnt;
    stall_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_adr.push_back(8'h10);
      rd_src.push_back(DW'(8'h55 + i));
      exp_rd.push_back(DW'(8'h55 + i));
    end
    issue_req(1'b0, 8'h10, 5'd3, 1'b0);
    repeat (10) tick();
    stall_hold = 1'b0;
    wait_done(d0, 100);
    total_cnt++;
    if (stall_stb_cnt - s0 != 10)
      $display("FAIL rd_stall_hold: got %0d stalled strobe cycles want 10", stall_stb_cnt - s0);
    else pass_cnt++;
    total_cnt++;
    if (rdv_cnt - r0 != 3 || exp_rd.size() != 0 || done_err !== 1'b0)
      $display("FAIL rd_stall_beats: got beats=%0d left=%0d err=%b want 3/0/0",
               rdv_cnt - r0, exp_rd.size(), done_err);
    else pass_cnt++;
    flush();
  endtask

  task automatic test_addr_wrap();
    int d0 = done_cnt, r0 = rdv_cnt;
    exp_adr.push_back(8'hFF); exp_adr.push_back(8'h00);
    rd_src.push_back(8'h11);  rd_src.push_back(8'h22);
    exp_rd.push_back(8'h11);  exp_rd.push_back(8'h22);
    issue_req(1'b0, 8'hFF, 5'd2, 1'b1);
    wait_done(d0, 100);
    total_cnt++;
    if (rdv_cnt - r0 != 2 || exp_adr.size() != 0 || done_err !== 1'b0)
      $display("FAIL wrap: got beats=%0d adr_left=%0d err=%b want 2/0/0",
               rdv_cnt - r0, exp_adr.size(), done_err);
    else pass_cnt++;
    flush();
  endtask

  task automatic test_len_clamp();
    int d0 = done_cnt, r0 = rdv_cnt;
    // len 0 behaves as a single beat
    exp_adr.push_back(8'h60);
    rd_src.push_back(8'hC0);
    exp_rd.push_back(8'hC0);
    issue_req(1'b0, 8'h60, 5'd0, 1'b1);
    wait_done(d0, 100);
    total_cnt++;
    if (rdv_cnt - r0 != 1 || exp_adr.size() != 0)
      $display("FAIL len0: got beats=%0d adr_left=%0d want 1/0", rdv_cnt - r0, exp_adr.size());
    else pass_cnt++;
    flush();
    // len 20 clamps to MAX_BURST, issued back-to-back with the previous burst
    d0 = done_cnt; r0 = rdv_cnt;
    for (int i = 0; i < MAX_BURST; i++) begin
      exp_adr.push_back(8'h70);
      rd_src.push_back(DW'(i + 1));
      exp_rd.push_back(DW'(i + 1));
    end
    for (int i = 0; i < 4; i++) rd_src.push_back(8'hEE);
    issue_req(1'b0, 8'h70, 5'd20, 1'b0);
    wait_done(d0, 200);
    total_cnt++;
    if (rdv_cnt - r0 != MAX_BURST || exp_adr.size() != 0 || done_err !== 1'b0)
      $display("FAIL len_clamp: got beats=%0d adr_left=%0d err=%b want %0d/0/0",
               rdv_cnt - r0, exp_adr.size(), done_err, MAX_BURST);
    else pass_cnt++;
    flush();
  endtask

  task automatic test_read_err();
    int d0 = done_cnt, r0 = rdv_cnt;
    err_at_ack = ack_num + 2;
    for (int i = 0; i < 4; i++) begin
      exp_adr.push_back(AW'(8'h30 + i));
      rd_src.push_back(DW'(8'h31 + i));
    end
    exp_rd.push_back(8'h31);
    issue_req(1'b0, 8'h30, 5'd4, 1'b1);
    wait_done(d0, 100);
    repeat (4) tick();
    total_cnt++;
    if (done_err !== 1'b1 || done_cyc_o !== 1'b0)
      $display("FAIL rd_err_abort: got err=%b cyc=%b want 1/0", done_err, done_cyc_o);
    else pass_cnt++;
    total_cnt++;
    if (rdv_cnt - r0 != 1 || done_cnt - d0 != 1)
      $display("FAIL rd_err_beats: got beats=%0d dones=%0d want 1/1", rdv_cnt - r0, done_cnt - d0);
    else pass_cnt++;
    err_at_ack = 0;
    flush();
  endtask

  task automatic test_timeout();
    int d0 = done_cnt, p0 = pop_cnt, s0 = stb_cnt;
    stall_hold = 1'b1;
    wr_fifo.push_back(8'hEE);
    exp_wdat.push_back(8'hEE);
    exp_adr.push_back(8'h50);
    issue_req(1'b1, 8'h50, 5'd1, 1'b1);
    wait_done(d0, 400);
    stall_hold = 1'b0;
    total_cnt++;
    if (done_err !== 1'b1 || done_cyc_o !== 1'b0 || pop_cnt - p0 != 0)
      $display("FAIL timeout_abort: got err=%b cyc=%b pops=%0d want 1/0/0",
               done_err, done_cyc_o, pop_cnt - p0);
    else pass_cnt++;
    total_cnt++;
    if (stb_cnt - s0 != TIMEOUT)
      $display("FAIL timeout_len: got %0d idle strobe cycles want %0d", stb_cnt - s0, TIMEOUT);
    else pass_cnt++;
    flush();
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt, r0 = rdv_cnt;
    for (int i = 0; i < 4; i++) begin
      exp_adr.push_back(AW'(8'h20 + i));
      rd_src.push_back(DW'(8'h61 + i));
    end
    issue_req(1'b0, 8'h20, 5'd4, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    total_cnt++;
    if (cyc_o !== 1'b0 || stb_o !== 1'b0 || done !== 1'b0)
      $display("FAIL rst_mid_drop: got cyc=%b stb=%b done=%b want 0/0/0", cyc_o, stb_o, done);
    else pass_cnt++;
    rst = 1'b0;
    repeat (6) tick();
    total_cnt++;
    if (done_cnt != d0 || rdv_cnt != r0)
      $display("FAIL rst_mid_quiet: got dones=%0d beats=%0d want 0/0", done_cnt - d0, rdv_cnt - r0);
    else pass_cnt++;
    flush();
    d0 = done_cnt; r0 = rdv_cnt;
    exp_adr.push_back(8'h40); exp_adr.push_back(8'h41);
    rd_src.push_back(8'h9A);  rd_src.push_back(8'h9B);
    exp_rd.push_back(8'h9A);  exp_rd.push_back(8'h9B);
    issue_req(1'b0, 8'h40, 5'd2, 1'b1);
    wait_done(d0, 100);
    total_cnt++;
    if (rdv_cnt - r0 != 2 || exp_rd.size() != 0 || done_err !== 1'b0)
      $display("FAIL rst_mid_after: got beats=%0d left=%0d err=%b want 2/0/0",
               rdv_cnt - r0, exp_rd.size(), done_err);
    else pass_cnt++;
    flush();
  endtask

  initial begin
    test_reset();
    test_write_incr();
    test_read_stall();
    test_addr_wrap();
    test_len_clamp();
    test_read_err();
    test_timeout();
    test_reset_mid();
    repeat (2) tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 SHALL have parameter AW, default 8, address width.
REQ-002 SHALL have parameter DW, default 8, data width.
REQ-003 SHALL have parameter MAX_BURST, default 16, max beats per request; LW = $clog2(MAX_BURST)+1.
REQ-004 SHALL have parameter TIMEOUT, default 255, idle cycles without accept/ack before abort.
REQ-005 SHALL have ports:
- clk  input  1  system clock; one clock domain.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request offered.
- req_ready  output  1  request accepted when req_valid && req_ready.
- req_we  input  1  1 = write burst, 0 = read burst.
- req_addr  input  AW  start address.
- req_len  input  LW  beat count, 1..MAX_BURST.
- req_incr  input  1  1 = address increments by 1 per beat; 0 = fixed address.
- wr_data  input  DW  next write beat, first-word-fall-through source.
- wr_pop  output  1  wr_data consumed this cycle.
- rd_data  output  DW  read beat.
- rd_valid  output  1  rd_data valid, one-cycle pulse per beat.
- done  output  1  one-cycle pulse, burst finished.
- err  output  1  one-cycle pulse with done, burst aborted.
- cyc_o, stb_o, we_o  output  1  Wishbone pipelined cycle/strobe/write.
- adr_o  output  AW; dat_o  output  DW; dat_i  input  DW.
- ack_i, stall_i, err_i  input  1  slave ack, stall, error.

Function
REQ-006 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> IDLE with registered outputs only.
REQ-007 req_ready SHALL be 1 only in IDLE; on handshake SHALL latch req_we, req_addr, req_incr and len; req_len = 0 SHALL be treated as 1; req_len > MAX_BURST SHALL be clamped to MAX_BURST.
REQ-008 Cycle after handshake SHALL enter ISSUE with cyc_o = stb_o = 1, we_o = latched we, adr_o = start address.
REQ-009 Beat issue: a beat SHALL be accepted in a cycle with stb_o && !stall_i; on accept adr_o SHALL advance by 1 (modulo 2^AW, wrapping) if incr, else hold; issued count +1.
REQ-010 Writes: dat_o SHALL equal wr_data while stb_o; wr_pop SHALL be 1 exactly in accept cycles.
REQ-011 While stall_i = 1, stb_o, adr_o, dat_o SHALL hold.
REQ-012 When the last beat is accepted, stb_o SHALL drop next cycle and FSM SHALL enter DRAIN; cyc_o SHALL stay 1.
REQ-013 Outstanding counter SHALL +1 per accept, -1 per ack_i, net 0 on same-cycle accept and ack; width LW.
REQ-014 Each ack_i with cyc_o = 1 on a read SHALL produce rd_valid = 1 and rd_data = dat_i in the following cycle (latency 1).
REQ-015 ack_i while cyc_o = 0 SHALL be ignored.
REQ-016 When acked count = len, next cycle SHALL: cyc_o = 0, done = 1, err = 0, FSM = IDLE; req_ready = 1 in that same cycle.
REQ-017 err_i with cyc_o = 1 SHALL abort: next cycle cyc_o = stb_o = 0, done = 1, err = 1, FSM = IDLE; no further rd_valid or wr_pop.
REQ-018 Timeout counter SHALL reset on handshake, accept or ack; on reaching TIMEOUT in ISSUE or DRAIN SHALL abort as REQ-017.
REQ-019 err_i and ack_i in the same cycle SHALL treat as error; that ack produces no rd_valid.

Reset
REQ-020 On rst = 1 at a clk edge: FSM = IDLE; counters = 0; cyc_o, stb_o, we_o, wr_pop, rd_valid, done, err = 0; adr_o, dat_o, rd_data = 0; req_ready = 0 during reset, 1 the cycle after rst falls.
REQ-021 Reset mid-burst SHALL drop cyc_o/stb_o next edge, emit no done/err; later acks SHALL be ignored.

Verification
REQ-022 Write, len 4, addr 0x80, incr, stall_i = 0, ack_i one cycle after each accept, wr_data 0xA0..0xA3 -> adr_o 0x80..0x83, dat_o 0xA0..0xA3, 4 wr_pop, done one cycle after 4th ack, err = 0.
REQ-023 Read, len 3, addr 0x10, fixed, stall_i = 1 for 10 cycles then 0, dat_i 0x55,0x56,0x57 -> stb_o/adr_o held 0x10 during stall, rd_data 0x55,0x56,0x57 on rd_valid, done.
REQ-024 Read, len 2, addr 0xFF, incr -> adr_o 0xFF then 0x00.
REQ-025 Read len 4, err_i on 2nd ack -> rd_valid once (first beat), done = err = 1, cyc_o = 0 next cycle.
REQ-026 Write len 1, stall_i held 1 for 300 cycles -> abort at 255 idle cycles, done = err = 1, wr_pop never asserted.
REQ-027 rst asserted mid-read -> cyc_o = 0 next edge, no done; new request accepted after reset with correct behaviour.
